// File: rtl/xcorr_iq_engine_if.sv
// xcorr_iq_engine_if: sample input and report/serial output bundle.
// master drives adc_d/adc_valid/snoop; slave (the engine) drives results.
interface xcorr_iq_engine_if #(
  parameter int ADC_W = 8,
  parameter int OUT_W = 8
);
  logic [ADC_W-1:0] adc_d;
  logic             adc_valid;
  logic             snoop;
  logic [OUT_W-1:0] corr_i;
  logic [OUT_W-1:0] corr_q;
  logic             report_valid;
  logic             ssp_clk;
  logic             ssp_frame;
  logic             ssp_din;
  logic             hyst_out;
  logic             dbg;

  modport master (
    output adc_d, adc_valid, snoop,
    input  corr_i, corr_q, report_valid,
    input  ssp_clk, ssp_frame, ssp_din,
    input  hyst_out, dbg
  );

  modport slave (
    input  adc_d, adc_valid, snoop,
    output corr_i, corr_q, report_valid,
    output ssp_clk, ssp_frame, ssp_din,
    output hyst_out, dbg
  );
endinterface

// File: rtl/xcorr_iq_engine.sv
// xcorr_iq_engine: I/Q subcarrier cross-correlator with SSP report path.
// Ports: adc_clk, rst_n (sync, active-low), bus (xcorr_iq_engine_if.slave).
// Optional XCORR_MAG_EN adds corr_mag = |corr_i|+|corr_q| of each report.
module xcorr_iq_engine #(
  parameter int ADC_W        = 8,
  parameter int SUB_LOG2     = 4,
  parameter int CYC_LOG2     = 2,
  parameter int OUT_W        = 8,
  parameter int HYST_TIMEOUT = 4095
) (
  input  logic adc_clk,
  input  logic rst_n,
`ifdef XCORR_MAG_EN
  output logic [OUT_W:0] corr_mag,
`endif
  xcorr_iq_engine_if.slave bus
);

  localparam int LOGN  = SUB_LOG2 + CYC_LOG2;
  localparam int N     = 1 << LOGN;
  localparam int ACC_W = ADC_W + LOGN + 1;
  localparam int SR_W  = 2 * OUT_W;
  localparam int QW    = LOGN - 2;
  localparam int LOW_W = $clog2(HYST_TIMEOUT + 1);

  localparam logic [LOGN-1:0]  HALF    = LOGN'(N / 2);
  localparam logic [LOGN:0]    SER_LIM = (LOGN + 1)'(8 * OUT_W);
  localparam logic [QW-1:0]    Q_MID   = QW'(OUT_W);
  localparam logic [LOW_W-1:0] LOW_MAX = LOW_W'(HYST_TIMEOUT);

  logic [LOGN-1:0]         cnt;
  logic                    first_flag;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic [SR_W-1:0]         sr;
  logic [OUT_W-1:0]        corr_i_r;
  logic [OUT_W-1:0]        corr_q_r;
  logic                    rv_r;
  logic                    ssp_clk_r;
  logic                    ssp_frame_r;
  logic                    hyst;
  logic                    hyst_prev;
  logic                    hyst_prev_prev;
  logic [LOW_W-1:0]        low_cnt;

  logic                    k_zero;
  logic                    ph_i;
  logic                    ph_q;
  logic                    do_report;
  logic                    in_ser;
  logic                    frame_hit;
  logic                    all1;
  logic                    all0;
  logic                    timeout;
  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] acc_i_nxt;
  logic signed [ACC_W-1:0] acc_q_nxt;
  logic [OUT_W-1:0]        ci_new;
  logic [OUT_W-1:0]        cq_new;

  always_comb begin
    k_zero    = (cnt == '0);
    ph_i      = cnt[SUB_LOG2-1];
    ph_q      = cnt[SUB_LOG2-2];
    do_report = bus.adc_valid && k_zero && !first_flag;
    in_ser    = ({1'b0, cnt} < SER_LIM);
    frame_hit = (cnt[LOGN-1:2] == '0) ||
                (cnt[LOGN-1:2] == Q_MID);
    all1      = &bus.adc_d;
    all0      = ~|bus.adc_d;
    timeout   = !hyst && (low_cnt == LOW_MAX);
    d_ext     = $signed({{(ACC_W-ADC_W){1'b0}}, bus.adc_d});
    acc_i_nxt = d_ext;
    acc_q_nxt = d_ext;
    if (!k_zero) begin
      acc_i_nxt = ph_i ? acc_i - d_ext
                       : acc_i + d_ext;
      acc_q_nxt = (ph_i == ph_q) ? acc_q + d_ext
                                 : acc_q - d_ext;
    end
    ci_new = acc_i[ACC_W-1 -: OUT_W];
    cq_new = acc_q[ACC_W-1 -: OUT_W];
    // in snoop mode the report LSBs carry the reader AM history
    if (bus.snoop) begin
      ci_new = {acc_i[ACC_W-1 -: OUT_W-1], hyst_prev_prev};
      cq_new = {acc_q[ACC_W-1 -: OUT_W-1], hyst_prev};
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      cnt            <= '0;
      first_flag     <= 1'b1;
      acc_i          <= '0;
      acc_q          <= '0;
      sr             <= '0;
      corr_i_r       <= '0;
      corr_q_r       <= '0;
      rv_r           <= 1'b0;
      ssp_clk_r      <= 1'b0;
      ssp_frame_r    <= 1'b0;
      hyst           <= 1'b0;
      hyst_prev      <= 1'b0;
      hyst_prev_prev <= 1'b0;
      low_cnt        <= '0;
    end else begin
      rv_r <= do_report;
      if (bus.adc_valid) begin
        cnt   <= cnt + 1'b1;
        acc_i <= acc_i_nxt;
        acc_q <= acc_q_nxt;
        if (k_zero) first_flag <= 1'b0;
        if (do_report) begin
          corr_i_r <= ci_new;
          corr_q_r <= cq_new;
          sr       <= {ci_new, cq_new};
          if (bus.snoop) hyst_prev_prev <= hyst;
        end else if (!k_zero && cnt[1:0] == 2'd0) begin
          sr <= {sr[SR_W-2:0], 1'b0};
        end
        if (cnt == HALF) hyst_prev <= hyst;
        if (!in_ser) ssp_clk_r <= 1'b0;
        else if (cnt[1:0] == 2'd0) ssp_clk_r <= 1'b1;
        else if (cnt[1:0] == 2'd2) ssp_clk_r <= 1'b0;
        ssp_frame_r <= frame_hit;
        // timeout wins over the data slicer
        if (hyst) begin
          low_cnt <= '0;
        end else if (timeout) begin
          hyst    <= 1'b1;
          low_cnt <= '0;
        end else begin
          low_cnt <= low_cnt + 1'b1;
        end
        if (!timeout) begin
          if (all1) hyst <= 1'b1;
          else if (all0) hyst <= 1'b0;
        end
      end
    end
  end

`ifdef XCORR_MAG_EN
  logic [OUT_W-1:0] mi;
  logic [OUT_W-1:0] mq;
  logic [OUT_W:0]   ai;
  logic [OUT_W:0]   aq;

  always_comb begin
    mi = ci_new;
    mq = cq_new;
    if (bus.snoop) begin
      mi[0] = 1'b0;
      mq[0] = 1'b0;
    end
    ai = {mi[OUT_W-1], mi};
    aq = {mq[OUT_W-1], mq};
    if (ai[OUT_W]) ai = ~ai + 1'b1;
    if (aq[OUT_W]) aq = ~aq + 1'b1;
  end

  always_ff @(posedge adc_clk) begin
    if (!rst_n) corr_mag <= '0;
    else if (do_report) corr_mag <= ai + aq;
  end
`else
  // default build: no magnitude path
`endif

  assign bus.corr_i       = corr_i_r;
  assign bus.corr_q       = corr_q_r;
  assign bus.report_valid = rv_r;
  assign bus.ssp_clk      = ssp_clk_r;
  assign bus.ssp_frame    = ssp_frame_r;
  assign bus.ssp_din      = sr[SR_W-1];
  assign bus.hyst_out     = hyst;
  assign bus.dbg          = cnt[SUB_LOG2-1];

endmodule

// File: tb/tb_xcorr_iq_engine.sv
// tb_xcorr_iq_engine: randomized and directed checks of xcorr_iq_engine
// against a window-sum reference model.
module tb_xcorr_iq_engine;

  localparam int ADC_W    = 8;
  localparam int SUB_LOG2 = 4;
  localparam int CYC_LOG2 = 2;
  localparam int OUT_W    = 8;
  localparam int TO       = 4095;
  localparam int N        = 1 << (SUB_LOG2 + CYC_LOG2);
  localparam int SUBP     = 1 << SUB_LOG2;
  localparam int SHR      = ADC_W + SUB_LOG2 + CYC_LOG2 + 1 - OUT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xcorr_iq_engine_if #(.ADC_W(ADC_W), .OUT_W(OUT_W)) bus ();

`ifdef XCORR_MAG_EN
  logic [OUT_W:0] corr_mag;
`endif

  xcorr_iq_engine #(
    .ADC_W(ADC_W), .SUB_LOG2(SUB_LOG2), .CYC_LOG2(CYC_LOG2),
    .OUT_W(OUT_W), .HYST_TIMEOUT(TO)
  ) dut (
    .adc_clk(clk),
    .rst_n(rst_n),
`ifdef XCORR_MAG_EN
    .corr_mag(corr_mag),
`endif
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  int         mk;
  bit         m_first;
  int         m_si, m_sq;
  bit         m_hyst, m_hp, m_hpp;
  int         m_low;
  logic [7:0] e_ci, e_cq;
  bit         e_rv, e_clk, e_frame;
  logic [15:0] m_sr;
  logic [8:0] e_mag;

  function automatic int sgn_i(input int k);
    return (((k / (SUBP / 2)) % 2) == 0) ? 1 : -1;
  endfunction

  function automatic int sgn_q(input int k);
    int qd;
    qd = (k / (SUBP / 4)) % 4;
    return (qd == 0 || qd == 3) ? 1 : -1;
  endfunction

  function automatic logic [7:0] word(input int s);
    int t;
    t = s >>> SHR;
    return t[7:0];
  endfunction

  function automatic logic [8:0] mag(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input bit s);
    logic [7:0] aa, bb;
    int x, y;
    aa = a;
    bb = b;
    if (s) begin
      aa[0] = 1'b0;
      bb[0] = 1'b0;
    end
    x = int'($signed(aa));
    y = int'($signed(bb));
    if (x < 0) x = -x;
    if (y < 0) y = -y;
    return 9'(x + y);
  endfunction

  task automatic model_update(input logic [7:0] d, input bit v,
                              input bit s, input bit r);
    logic [7:0] wi, wq;
    if (!r) begin
      mk = 0; m_first = 1; m_si = 0; m_sq = 0;
      m_hyst = 0; m_hp = 0; m_hpp = 0; m_low = 0;
      e_ci = 0; e_cq = 0; e_rv = 0; e_clk = 0;
      e_frame = 0; m_sr = 0; e_mag = 0;
    end else begin
      e_rv = 0;
      if (v) begin
        if (mk == 0) begin
          if (!m_first) begin
            wi = word(m_si);
            wq = word(m_sq);
            if (s) begin
              wi[0] = m_hpp;
              wq[0] = m_hp;
              m_hpp = m_hyst;
            end
            e_ci = wi; e_cq = wq; e_rv = 1;
            m_sr = {wi, wq};
            e_mag = mag(wi, wq, s);
          end
          m_first = 0; m_si = 0; m_sq = 0;
        end else if (mk % 4 == 0) begin
          m_sr = m_sr << 1;
        end
        m_si += sgn_i(mk) * int'(d);
        m_sq += sgn_q(mk) * int'(d);
        if (mk == N / 2) m_hp = m_hyst;
        if (mk < 8 * OUT_W) begin
          if (mk % 4 == 0) e_clk = 1;
          else if (mk % 4 == 2) e_clk = 0;
        end else begin
          e_clk = 0;
        end
        e_frame = (mk / 4 == 0) || (mk / 4 == OUT_W);
        if (!m_hyst && m_low == TO) begin
          m_hyst = 1; m_low = 0;
        end else begin
          if (m_hyst) m_low = 0;
          else m_low++;
          if (d == 8'hFF) m_hyst = 1;
          else if (d == 8'h00) m_hyst = 0;
        end
        mk = (mk + 1) % N;
      end
    end
  endtask

  task automatic step(input logic [7:0] d, input bit v, input bit s);
    bus.adc_d = d;
    bus.adc_valid = v;
    bus.snoop = s;
    @(posedge clk);
    model_update(d, v, s, rst_n);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] sq_pat(input int n);
    return ((n % SUBP) < SUBP / 2) ? 8'hFF : 8'h00;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step(8'h55, 1'b1, 1'b1);
    step(8'hFF, 1'b1, 1'b1);
    checks++;
    if (bus.corr_i !== 8'h00) begin
      errors++; $display("FAIL reset_corr_i got %h want 00", bus.corr_i);
    end
    checks++;
    if (bus.corr_q !== 8'h00) begin
      errors++; $display("FAIL reset_corr_q got %h want 00", bus.corr_q);
    end
    checks++;
    if (bus.report_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rv got %b want 0", bus.report_valid);
    end
    checks++;
    if ({bus.ssp_clk, bus.ssp_frame, bus.ssp_din} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ssp got %b%b%b want 000",
               bus.ssp_clk, bus.ssp_frame, bus.ssp_din);
    end
    checks++;
    if ({bus.hyst_out, bus.dbg} !== 2'b00) begin
      errors++;
      $display("FAIL reset_hyst_dbg got %b%b want 00", bus.hyst_out, bus.dbg);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_const();
    int strobes, last;
    apply_reset();
    strobes = 0;
    last = 0;
    for (int i = 0; i < 3 * N + 1; i++) begin
      step(8'd128, 1'b1, 1'b0);
      checks++;
      if (bus.report_valid !== e_rv) begin
        errors++;
        $display("FAIL const_rv i=%0d got %b want %b", i, bus.report_valid, e_rv);
      end
      if (bus.report_valid === 1'b1) begin
        checks++;
        if (i - last != N) begin
          errors++; $display("FAIL const_spacing got %0d want %0d", i - last, N);
        end
        checks++;
        if (bus.corr_i !== 8'h00 || bus.corr_q !== 8'h00) begin
          errors++;
          $display("FAIL const_corr got %h/%h want 00/00", bus.corr_i, bus.corr_q);
        end
        strobes++;
        last = i;
      end
    end
    checks++;
    if (strobes != 3) begin
      errors++; $display("FAIL const_strobes got %0d want 3", strobes);
    end
  endtask

  task automatic test_square();
    int strobes;
    apply_reset();
    strobes = 0;
    for (int i = 0; i < 3 * N + 1; i++) begin
      step(sq_pat(i), 1'b1, 1'b0);
      if (bus.report_valid === 1'b1) begin
        strobes++;
        checks++;
        if (bus.corr_i !== 8'h3F || bus.corr_q !== 8'h00) begin
          errors++;
          $display("FAIL square_corr got %h/%h want 3f/00", bus.corr_i, bus.corr_q);
        end
        checks++;
        if (bus.corr_i !== e_ci || bus.corr_q !== e_cq) begin
          errors++;
          $display("FAIL square_model got %h/%h want %h/%h",
                   bus.corr_i, bus.corr_q, e_ci, e_cq);
        end
      end
    end
    checks++;
    if (strobes != 3) begin
      errors++; $display("FAIL square_strobes got %0d want 3", strobes);
    end
  endtask

  task automatic test_valid_toggle();
    int vi, last, strobes;
    bit v;
    logic [7:0] pci, pcq, d;
    logic pclk, pfr;
    apply_reset();
    vi = 0;
    last = 0;
    strobes = 0;
    for (int i = 0; i < 2 * (3 * N + 1); i++) begin
      v = (i % 2 == 0);
      d = v ? sq_pat(vi) : 8'($urandom);
      if (v) vi++;
      pci = bus.corr_i; pcq = bus.corr_q;
      pclk = bus.ssp_clk; pfr = bus.ssp_frame;
      step(d, v, 1'b0);
      if (!v) begin
        checks++;
        if (bus.corr_i !== pci || bus.corr_q !== pcq ||
            bus.ssp_clk !== pclk || bus.ssp_frame !== pfr ||
            bus.report_valid !== 1'b0) begin
          errors++;
          $display("FAIL toggle_hold i=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/0",
                   i, bus.corr_i, bus.corr_q, bus.ssp_clk, bus.ssp_frame,
                   bus.report_valid, pci, pcq, pclk, pfr);
        end
      end
      if (bus.report_valid === 1'b1) begin
        strobes++;
        checks++;
        if (i - last != 2 * N) begin
          errors++;
          $display("FAIL toggle_spacing got %0d want %0d", i - last, 2 * N);
        end
        checks++;
        if (bus.corr_i !== 8'h3F || bus.corr_q !== 8'h00) begin
          errors++;
          $display("FAIL toggle_corr got %h/%h want 3f/00", bus.corr_i, bus.corr_q);
        end
        last = i;
      end
    end
    checks++;
    if (strobes != 3) begin
      errors++; $display("FAIL toggle_strobes got %0d want 3", strobes);
    end
  endtask

  task automatic test_snoop_hyst();
    int rep;
    apply_reset();
    rep = 0;
    for (int i = 0; i < 3 * N + 1; i++) begin
      step(8'hFF, 1'b1, 1'b1);
      if (bus.report_valid === 1'b1) begin
        rep++;
        checks++;
        if (bus.corr_i !== e_ci || bus.corr_q !== e_cq) begin
          errors++;
          $display("FAIL snoop_model got %h/%h want %h/%h",
                   bus.corr_i, bus.corr_q, e_ci, e_cq);
        end
        checks++;
        if (rep == 1 && {bus.corr_i[0], bus.corr_q[0]} !== 2'b01) begin
          errors++;
          $display("FAIL snoop_lsb1 got %b%b want 01", bus.corr_i[0], bus.corr_q[0]);
        end else if (rep >= 2 && (bus.corr_i !== 8'h01 || bus.corr_q !== 8'h01)) begin
          errors++;
          $display("FAIL snoop_lsb2 got %h/%h want 01/01", bus.corr_i, bus.corr_q);
        end
      end
    end
    checks++;
    if (bus.hyst_out !== 1'b1) begin
      errors++; $display("FAIL hyst_high got %b want 1", bus.hyst_out);
    end
    step(8'h00, 1'b1, 1'b1);
    checks++;
    if (bus.hyst_out !== 1'b0) begin
      errors++; $display("FAIL hyst_low got %b want 0", bus.hyst_out);
    end
    for (int j = 1; j < TO + 1; j++) begin
      step(8'h40, 1'b1, 1'b1);
      checks++;
      if (bus.hyst_out !== m_hyst) begin
        errors++;
        $display("FAIL hyst_run j=%0d got %b want %b", j, bus.hyst_out, m_hyst);
      end
    end
    checks++;
    if (bus.hyst_out !== 1'b0) begin
      errors++; $display("FAIL hyst_pre_timeout got %b want 0", bus.hyst_out);
    end
    step(8'h40, 1'b1, 1'b1);
    checks++;
    if (bus.hyst_out !== 1'b1) begin
      errors++; $display("FAIL hyst_timeout got %b want 1", bus.hyst_out);
    end
  endtask

  task automatic test_serial();
    logic [15:0] bits, exp_w;
    int nrise;
    logic prev_clk;
    bit fr;
    apply_reset();
    for (int i = 0; i < N; i++) step(8'($urandom), 1'b1, 1'b0);
    for (int w = 0; w < 2; w++) begin
      bits = '0;
      exp_w = '0;
      nrise = 0;
      prev_clk = bus.ssp_clk;
      for (int kk = 0; kk < N; kk++) begin
        step(8'($urandom), 1'b1, 1'b0);
        if (kk == 0) begin
          exp_w = {e_ci, e_cq};
          checks++;
          if (bus.report_valid !== 1'b1 || {bus.corr_i, bus.corr_q} !== exp_w) begin
            errors++;
            $display("FAIL serial_report rv=%b got %h%h want %h",
                     bus.report_valid, bus.corr_i, bus.corr_q, exp_w);
          end
        end
        if (prev_clk === 1'b0 && bus.ssp_clk === 1'b1) begin
          bits = {bits[14:0], bus.ssp_din};
          nrise++;
        end
        prev_clk = bus.ssp_clk;
        fr = (kk < 4) || (kk >= 4 * OUT_W && kk < 4 * OUT_W + 4);
        checks++;
        if (bus.ssp_frame !== fr) begin
          errors++;
          $display("FAIL serial_frame k=%0d got %b want %b", kk, bus.ssp_frame, fr);
        end
      end
      checks++;
      if (nrise != 16) begin
        errors++; $display("FAIL serial_edges got %0d want 16", nrise);
      end
      checks++;
      if (bits !== exp_w) begin
        errors++; $display("FAIL serial_bits got %h want %h", bits, exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first;
    apply_reset();
    for (int i = 0; i < N + 20; i++) step(8'($urandom), 1'b1, 1'b0);
    rst_n = 1'b0;
    step(8'($urandom), 1'b1, 1'b0);
    checks++;
    if ({bus.corr_i, bus.corr_q} !== 16'h0000 || bus.report_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_corr got %h/%h rv=%b want 00/00 rv=0",
               bus.corr_i, bus.corr_q, bus.report_valid);
    end
    checks++;
    if ({bus.ssp_clk, bus.ssp_frame, bus.ssp_din, bus.hyst_out, bus.dbg} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_misc got %b%b%b%b%b want 00000", bus.ssp_clk,
               bus.ssp_frame, bus.ssp_din, bus.hyst_out, bus.dbg);
    end
    rst_n = 1'b1;
    first = -1;
    for (int i = 0; i < 2 * N + 1; i++) begin
      step(8'($urandom), 1'b1, 1'b0);
      if (bus.report_valid === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first != N) begin
      errors++; $display("FAIL midrst_first_strobe got %0d want %0d", first, N);
    end
  endtask

  task automatic test_random();
    bit v, s;
    int r;
    logic [7:0] d;
    bit edbg;
    apply_reset();
    s = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) s = bit'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
      step(d, v, s);
      edbg = bit'((mk >> (SUB_LOG2 - 1)) & 1);
      checks++;
      if (bus.corr_i !== e_ci || bus.corr_q !== e_cq ||
          bus.report_valid !== e_rv) begin
        errors++;
        $display("FAIL rand_corr i=%0d got %h/%h/%b want %h/%h/%b", i,
                 bus.corr_i, bus.corr_q, bus.report_valid, e_ci, e_cq, e_rv);
      end
      checks++;
      if (bus.ssp_clk !== e_clk || bus.ssp_frame !== e_frame ||
          bus.ssp_din !== m_sr[15]) begin
        errors++;
        $display("FAIL rand_ssp i=%0d got %b%b%b want %b%b%b", i, bus.ssp_clk,
                 bus.ssp_frame, bus.ssp_din, e_clk, e_frame, m_sr[15]);
      end
      checks++;
      if (bus.hyst_out !== m_hyst || bus.dbg !== edbg) begin
        errors++;
        $display("FAIL rand_hyst_dbg i=%0d got %b%b want %b%b", i,
                 bus.hyst_out, bus.dbg, m_hyst, edbg);
      end
`ifdef XCORR_MAG_EN
      checks++;
      if (corr_mag !== e_mag) begin
        errors++; $display("FAIL rand_mag i=%0d got %0d want %0d", i, corr_mag, e_mag);
      end
`endif
    end
  endtask

  initial begin
    bus.adc_d = '0;
    bus.adc_valid = 1'b0;
    bus.snoop = 1'b0;
    test_reset();
    test_const();
    test_square();
    test_valid_toggle();
    test_snoop_hyst();
    test_serial();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
